// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: data word, ALU function
// encoding, and the instruction word that carries the function to the ALU.
package alu_arbiter_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned SHAMT_W   = 5;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_fn_t;

    // Minimal decoded instruction; the arbiter only ever overrides alu_fn.
    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [REG_IDX_W-1:0] rd;
        alu_fn_t              alu_fn;
    } instruction_t;

    // addi x0, x0, 0 -- a harmless carrier for an ALU-only operation.
    localparam instruction_t instr_nop = '{
        opcode: OPCODE_W'(7'h13),
        rd:     REG_IDX_W'(0),
        alu_fn: ALU_ADD
    };

    // Occupancy of the one-entry result register.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/arith_logic_unit.sv
// Purely combinational 32-bit ALU. Add/sub wrap modulo 2^32; shift amounts
// use the low five bits of operand b.
module arith_logic_unit
    import alu_arbiter_pkg::*;
(
    input  instruction_t instr,
    input  word_t        a,
    input  word_t        b,
    output word_t        result_c
);

    logic [SHAMT_W-1:0] shamt;
    logic               unused_instr_bits;

    assign shamt             = b[SHAMT_W-1:0];
    assign unused_instr_bits = ^{instr.opcode, instr.rd};

    // Function select; unknown encodings produce zero.
    always_comb begin
        result_c = '0;
        case (instr.alu_fn)
            ALU_ADD:  result_c = a + b;
            ALU_SUB:  result_c = a - b;
            ALU_SLL:  result_c = a << shamt;
            ALU_SLT:  result_c = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result_c = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result_c = a ^ b;
            ALU_SRL:  result_c = a >> shamt;
            ALU_SRA:  result_c = word_t'($signed(a) >>> shamt);
            ALU_OR:   result_c = a | b;
            ALU_AND:  result_c = a & b;
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU. A combinational arbiter picks one request per
// cycle; its result lands in a one-entry register one cycle later. Drain and
// accept in the same cycle keep the register full, giving 1 op/cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic    clk,
    input  logic    reset,

    input  logic    req0_valid,
    output logic    req0_ready,
    input  alu_fn_t req0_fn,
    input  word_t   req0_a,
    input  word_t   req0_b,

    input  logic    req1_valid,
    output logic    req1_ready,
    input  alu_fn_t req1_fn,
    input  word_t   req1_a,
    input  word_t   req1_b,

    output logic    rsp_valid,
    input  logic    rsp_ready,
    output logic    rsp_id,
    output word_t   rsp_r
);

    localparam bit USE_FIXED = (FIXED_PRIORITY != 0);

    slot_state_t  state_q;
    slot_state_t  state_d;
    logic         prio_q;
    logic         prio_d;

    logic         both_valid_c;
    logic         prio_eff_c;
    logic         grant_c;
    logic         slot_free_c;
    logic         accept_c;

    alu_fn_t      grant_fn_c;
    word_t        grant_a_c;
    word_t        grant_b_c;
    instruction_t alu_instr_c;
    word_t        alu_result_c;

    // Arbitration, handshake and next-state / next-priority decisions.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        grant_c      = 1'b0;
        accept_c     = 1'b0;
        both_valid_c = req0_valid && req1_valid;
        prio_eff_c   = USE_FIXED ? 1'b0 : prio_q;
        slot_free_c  = (state_q == SLOT_EMPTY) || rsp_ready;

        if (both_valid_c) begin
            grant_c = prio_eff_c;
        end else if (req1_valid) begin
            grant_c = 1'b1;
        end

        if (!reset && slot_free_c) begin
            req0_ready = req0_valid && !grant_c;
            req1_ready = req1_valid && grant_c;
        end
        accept_c = req0_ready || req1_ready;

        case (state_q)
            SLOT_EMPTY: begin
                if (accept_c) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (accept_c) begin
                    state_d = SLOT_FULL;
                end else if (rsp_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase

        // The loser of a contested grant goes first next time.
        if (!USE_FIXED && accept_c && both_valid_c) begin
            prio_d = !grant_c;
        end
    end

    // Steer the granted requester's operation onto the shared ALU.
    always_comb begin
        grant_fn_c         = grant_c ? req1_fn : req0_fn;
        grant_a_c          = grant_c ? req1_a  : req0_a;
        grant_b_c          = grant_c ? req1_b  : req0_b;
        alu_instr_c        = instr_nop;
        alu_instr_c.alu_fn = grant_fn_c;
    end

    arith_logic_unit u_alu (
        .instr    (alu_instr_c),
        .a        (grant_a_c),
        .b        (grant_b_c),
        .result_c (alu_result_c)
    );

    // Result-register occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result payload and round-robin pointer; a pending result is dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_r  <= '0;
            rsp_id <= 1'b0;
            prio_q <= 1'b0;
        end else begin
            if (accept_c) begin
                rsp_r  <= alu_result_c;
                rsp_id <= grant_c;
            end
            prio_q <= prio_d;
        end
    end

    assign rsp_valid = (state_q == SLOT_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus; each has its own reference model and
// expected-result queue.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    req0_valid, req1_valid, rsp_ready;
    alu_fn_t req0_fn, req1_fn;
    word_t   req0_a, req0_b, req1_a, req1_b;

    logic    rdy0 [2];
    logic    rdy1 [2];
    logic    vld  [2];
    logic    rid  [2];
    word_t   rr   [2];

    typedef struct packed {
        logic  id;
        word_t r;
    } exp_t;

    exp_t sb0 [$];
    exp_t sb1 [$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: results the consumer has not yet taken, and whose turn it is.
    int   held   [2];
    int   turn   [2];

    alu_fn_t fns [10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                          ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

    always #5 clk = ~clk;

    alu_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_fn(req0_fn), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_fn(req1_fn), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_r(rr[0])
    );

    alu_arbiter #(.FIXED_PRIORITY(1)) dut_fx (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_fn(req0_fn), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_fn(req1_fn), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_r(rr[1])
    );

    function automatic word_t alu_ref(alu_fn_t fn, word_t a, word_t b);
        int unsigned sh;
        sh = int'(b % 32);
        case (fn)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return word_t'($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic int sb_size(int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t sb_front(int k);
        return (k == 0) ? sb0[0] : sb1[0];
    endfunction

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                for (int k = 0; k < 2; k++) begin
                    if (vld[k]) begin
                        if (sb_size(k) == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL spurious_rsp[%0d]: got id %0d r %h, required no result", k, rid[k], rr[k]);
                        end else begin
                            e = sb_front(k);
                            check($sformatf("rsp_id[%0d]", k), 32'(rid[k]), 32'(e.id));
                            check($sformatf("rsp_r[%0d]", k), rr[k], e.r);
                            if (rsp_ready) begin
                                if (k == 0) void'(sb0.pop_front());
                                else        void'(sb1.pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    // Reference model: decides who should be accepted this cycle and what it yields.
    initial begin : model
        int   winner;
        bit   can_take;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            held[k] = 0;
            turn[k] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                winner = -1;
                can_take = (held[k] == 0) || (rsp_ready == 1'b1);
                if (req0_valid && req1_valid)      winner = (k == 1) ? 0 : turn[k];
                else if (req0_valid)               winner = 0;
                else if (req1_valid)               winner = 1;
                if (reset || !can_take)            winner = -1;

                check($sformatf("req0_ready[%0d]", k), 32'(rdy0[k]), 32'(winner == 0));
                check($sformatf("req1_ready[%0d]", k), 32'(rdy1[k]), 32'(winner == 1));
                if (!reset) check($sformatf("rsp_valid[%0d]", k), 32'(vld[k]), 32'(held[k] != 0));

                if (reset) begin
                    held[k] = 0;
                    turn[k] = 0;
                    if (k == 0) sb0.delete();
                    else        sb1.delete();
                end else if (winner >= 0) begin
                    e.id = (winner == 1);
                    e.r  = (winner == 1) ? alu_ref(req1_fn, req1_a, req1_b)
                                         : alu_ref(req0_fn, req0_a, req0_b);
                    if (k == 0) sb0.push_back(e);
                    else        sb1.push_back(e);
                    held[k] = 1;
                    if (req0_valid && req1_valid && k == 0) turn[k] = 1 - winner;
                end else if (rsp_ready) begin
                    held[k] = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input alu_fn_t f0, input word_t a0, input word_t b0,
                         input logic v1, input alu_fn_t f1, input word_t a1, input word_t b1,
                         input logic rdy);
        req0_valid = v0; req0_fn = f0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_fn = f1; req1_a = a1; req1_b = b1;
        rsp_ready  = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0, ALU_ADD, 32'd0, 32'd0, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1'b0);
        cyc();
        reset = 1'b0;
    endtask

    initial begin : stimulus
        word_t exp_r [4];
        exp_r[0] = 32'hFFFF_FFF6; exp_r[1] = 32'hFFFF_0005;
        exp_r[2] = 32'hFFFF_FFF6; exp_r[3] = 32'hFFFF_0005;

        reset = 1'b1;
        idle(1'b0);
        repeat (3) cyc();
        check("reset_rsp_valid_rr", 32'(vld[0]), 32'd0);
        check("reset_rsp_r_rr", rr[0], 32'd0);
        reset = 1'b0;

        // Single ADD, one-cycle latency, drains the next cycle.
        drive(1'b1, ALU_ADD, 32'd10, 32'd20, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1);
        cyc();
        check("add_valid", 32'(vld[0]), 32'd1);
        check("add_id", 32'(rid[0]), 32'd0);
        check("add_r", rr[0], 32'd30);
        idle(1'b1);
        cyc();
        check("add_empty", 32'(vld[0]), 32'd0);

        // Both requesting every cycle: alternation vs fixed priority.
        do_reset();
        drive(1'b1, ALU_SUB, 32'd10, 32'd20, 1'b1, ALU_SRA, 32'hF000_5432, 32'd12, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("rr_alt_r%0d", i), rr[0], exp_r[i]);
            check($sformatf("rr_alt_id%0d", i), 32'(rid[0]), 32'(i % 2));
            check($sformatf("fx_r%0d", i), rr[1], 32'hFFFF_FFF6);
            check($sformatf("fx_req1_ready%0d", i), 32'(rdy1[1]), 32'd0);
        end
        idle(1'b1);
        cyc();

        // Back-pressure: result held, waiting requester stalled until release.
        do_reset();
        drive(1'b1, ALU_ADD, 32'd1, 32'd1, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
        cyc();
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1, ALU_XOR, 32'd3, 32'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("stall_r%0d", i), rr[0], 32'd2);
            check($sformatf("stall_ready%0d", i), 32'(rdy1[0]), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("release_ready", 32'(rdy1[0]), 32'd1);
        cyc();
        check("release_r", rr[0], 32'd6);
        check("release_id", 32'(rid[0]), 32'd1);
        idle(1'b1);
        cyc();

        // Reset while a result is pending discards it.
        do_reset();
        drive(1'b1, ALU_SLL, 32'h0001_2345, 32'd12, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b0);
        cyc();
        check("sll_pending_r", rr[0], 32'h1234_5000);
        reset = 1'b1;
        idle(1'b0);
        cyc();
        reset = 1'b0;
        check("reset_drop_valid_rr", 32'(vld[0]), 32'd0);
        check("reset_drop_valid_fx", 32'(vld[1]), 32'd0);
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1, ALU_SLTU, 32'd10, 32'hFFFF_FFEC, 1'b1);
        cyc();
        check("sltu_r", rr[0], 32'd1);
        check("sltu_id", 32'(rid[0]), 32'd1);
        idle(1'b1);
        cyc();

        // Lone requesters leave the pointer alone.
        do_reset();
        drive(1'b1, ALU_OR, 32'd1, 32'd2, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1); cyc();
        idle(1'b1); cyc();
        drive(1'b1, ALU_OR, 32'd4, 32'd2, 1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1); cyc();
        idle(1'b1); cyc();
        drive(1'b0, ALU_ADD, 32'd0, 32'd0, 1'b1, ALU_AND, 32'd7, 32'd3, 1'b1); cyc();
        idle(1'b1); cyc();
        drive(1'b1, ALU_ADD, 32'd5, 32'd5, 1'b1, ALU_SUB, 32'd5, 32'd5, 1'b1); cyc();
        check("prio_kept_id", 32'(rid[0]), 32'd0);
        check("prio_kept_r", rr[0], 32'd10);
        idle(1'b1);
        cyc();

        // Randomized traffic with back-pressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, fns[$urandom_range(0, 9)], word_t'($urandom()),
                  ($urandom_range(0, 1) != 0) ? word_t'($urandom_range(0, 40)) : word_t'($urandom()),
                  $urandom_range(0, 3) != 0, fns[$urandom_range(0, 9)], word_t'($urandom()),
                  ($urandom_range(0, 1) != 0) ? word_t'($urandom_range(0, 40)) : word_t'($urandom()),
                  $urandom_range(0, 3) != 0);
            cyc();
        end

        reset = 1'b0;
        idle(1'b1);
        repeat (3) cyc();
        check("drain_rr", 32'(sb0.size()), 32'd0);
        check("drain_fx", 32'(sb1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin and 1 = requester 0 always wins.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 bit, requester i presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1 bit, operation of requester i accepted this cycle.
REQ-006 SHALL have ports req0_fn/req1_fn, input, alu_fn_t, ALU function of requester i.
REQ-007 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, word_t, operands of requester i.
REQ-008 SHALL have port rsp_valid, output, 1 bit, the result register holds a result.
REQ-009 SHALL have port rsp_ready, input, 1 bit, the consumer takes the result this cycle.
REQ-010 SHALL have port rsp_id, output, 1 bit, index of the requester that owns the result.
REQ-011 SHALL have port rsp_r, output, word_t, the ALU result.

Function
REQ-012 SHALL share one arith_logic_unit between the two requesters.
- ALU instr = instr_nop with alu_fn set to the granted fn.
- ALU a/b = granted operands.
REQ-013 SHALL keep a one-entry result register with two states:
- EMPTY (rsp_valid=0).
- FULL (rsp_valid=1).
REQ-014 SHALL define a slot as free when state is EMPTY, or when state is FULL and rsp_ready=1.
REQ-015 SHALL make the grant decision combinationally:
- Only requester i valid -> grant i.
- Both valid -> grant the requester selected by priority pointer prio; prio is 0 when FIXED_PRIORITY=1.
REQ-016 SHALL assert reqi_ready exactly when i is granted, the slot is free and reset=0; at most one ready per cycle.
REQ-017 SHALL handle acceptance (valid&ready) at edge N as follows:
- rsp_r <= ALU result and rsp_id <= i.
- State becomes FULL, so rsp_valid=1 from cycle N+1.
- Latency is exactly 1 cycle.
REQ-018 SHALL go FULL -> EMPTY when rsp_ready=1 and there is no acceptance.
REQ-019 SHALL treat simultaneous drain and accept as follows:
- State stays FULL and the register is loaded with the new result.
- Full throughput of 1 operation/cycle.
REQ-020 SHALL hold rsp_r, rsp_id and rsp_valid stable while FULL and rsp_ready=0; both reqi_ready SHALL be 0 in that case.
REQ-021 SHALL update prio only when both requesters are valid and an acceptance occurs: prio <= index of the loser.
- A lone-requester acceptance leaves prio unchanged.
REQ-022 SHALL leave ALU results unmodified: 32-bit wrap on add/sub, shift amount = b[4:0], per the ALU's definition.
REQ-023 SHALL not depend on rsp_ready in EMPTY; rsp_ready while EMPTY is ignored.

Reset
REQ-024 SHALL, while reset=1 at an edge, set state EMPTY, rsp_valid=0, rsp_id=0, rsp_r=0 and prio=0.
REQ-025 SHALL hold req0_ready=req1_ready=0 during reset; a request presented in the reset cycle is not accepted.
REQ-026 SHALL discard a result pending when reset is asserted mid-operation; it is never delivered.

Structure
REQ-027 SHALL take word_t, alu_fn_t, instruction_t and instr_nop from the existing shared packages; no new package content is needed.
REQ-028 SHALL instantiate arith_logic_unit as its only sub-module; the arbiter and the result register are local logic.

Verification
REQ-029 SHALL cover: req0 ADD 10,20, rsp_ready=1 -> req0_ready in cycle 0, rsp_valid/rsp_id=0/rsp_r=30 in cycle 1, EMPTY in cycle 2.
REQ-030 SHALL cover: both valid every cycle after reset, rsp_ready=1, req0 SUB 10,20 and req1 SRA F0005432,12:
- Grants alternate 0,1,0,1.
- Results alternate FFFFFFF6 and FFFF0005 with one result per cycle.
REQ-031 SHALL cover: FULL with rsp_ready=0 for 3 cycles while req1 waits with XOR 3,5:
- rsp_r stays stable and req1_ready=0.
- Release rsp_ready -> req1 is accepted in the same cycle and rsp_r=6 next.
REQ-032 SHALL cover: FIXED_PRIORITY=1, both valid for 3 cycles -> req0 granted all 3 cycles; req1_ready=0 throughout.
REQ-033 SHALL cover: accept SLL 12345,12, then assert reset on the next edge -> rsp_valid=0 and 12345000 is never delivered; after reset req1 alone, SLTU 10,-20 -> rsp_r=1, rsp_id=1.
REQ-034 SHALL cover: alternate single requesters 0,0,1 with both idle between -> prio unchanged (0); then both valid -> req0 granted.
